// File: rtl/gray_decoder.sv
// Gray-code link receiver: decodes sampled Gray to binary, checks single-step moves, tracks wraps.
// Optional down-step support is enabled by defining GRAY_DOWN_EN.
module gray_decoder #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Resync,
  input  logic [WIDTH-1:0]  Gray,
  output logic [WIDTH-1:0]  Bin,
  output logic              Locked,
  output logic              Up,
  output logic              Down,
  output logic              Err,
  output logic              Error,
  output logic              Overflow,
  output logic [WRAP_W-1:0] WrapCnt
);

  typedef enum logic [1:0] {UNLOCKED, TRACK, FAULT} state_t;

  localparam logic [WIDTH-1:0]  BIN_ONE  = 1;
  localparam logic [WIDTH-1:0]  BIN_ONES = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_t             state_p0, state_p1;
  logic [WIDTH-1:0]   bin_p0, bin_p1;
  logic               up_p0, up_p1;
  logic               err_p0, err_p1;
  logic               error_p0, error_p1;
  logic               ovf_p0, ovf_p1;
  logic [WRAP_W-1:0]  wrap_p0, wrap_p1;
  logic [WIDTH-1:0]   dec_p0, delta_p0;
`ifdef GRAY_DOWN_EN
  logic               down_p0, down_p1;
`endif

  // Stage 0: combinational decode and step classification
  always_comb begin
    state_p0 = state_p1;
    bin_p0   = bin_p1;
    up_p0    = 1'b0;
    err_p0   = 1'b0;
    error_p0 = error_p1;
    ovf_p0   = ovf_p1;
    wrap_p0  = wrap_p1;
`ifdef GRAY_DOWN_EN
    down_p0  = 1'b0;
`endif
    dec_p0   = gray2bin(Gray);
    delta_p0 = dec_p0 - bin_p1;
    if (Resync) begin
      state_p0 = UNLOCKED;
      error_p0 = 1'b0;
    end else if (En) begin
      unique case (state_p1)
        UNLOCKED: begin
          bin_p0   = dec_p0;
          state_p0 = TRACK;
        end
        TRACK: begin
          if (delta_p0 == '0) begin
            bin_p0 = bin_p1;
          end else if (delta_p0 == BIN_ONE) begin
            bin_p0 = dec_p0;
            up_p0  = 1'b1;
            // A +1 step from all-ones necessarily lands on zero
            if (bin_p1 == BIN_ONES) begin
              ovf_p0 = 1'b1;
              if (wrap_p1 != WRAP_MAX) wrap_p0 = wrap_p1 + WRAP_ONE;
            end
`ifdef GRAY_DOWN_EN
          end else if (delta_p0 == BIN_ONES) begin
            bin_p0  = dec_p0;
            down_p0 = 1'b1;
            if (bin_p1 == '0 && wrap_p1 != '0) wrap_p0 = wrap_p1 - WRAP_ONE;
`endif
          end else begin
            err_p0   = 1'b1;
            error_p0 = 1'b1;
            state_p0 = FAULT;
          end
        end
        default: begin
          state_p0 = state_p1;
        end
      endcase
    end
  end

  // Stage 1: registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_p1 <= UNLOCKED;
      bin_p1   <= '0;
      up_p1    <= 1'b0;
      err_p1   <= 1'b0;
      error_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      wrap_p1  <= '0;
    end else begin
      state_p1 <= state_p0;
      bin_p1   <= bin_p0;
      up_p1    <= up_p0;
      err_p1   <= err_p0;
      error_p1 <= error_p0;
      ovf_p1   <= ovf_p0;
      wrap_p1  <= wrap_p0;
    end
  end

`ifdef GRAY_DOWN_EN
  always_ff @(posedge Clk) begin
    if (Reset) down_p1 <= 1'b0;
    else       down_p1 <= down_p0;
  end
  assign Down = down_p1;
`else
  assign Down = 1'b0;
`endif

  assign Bin      = bin_p1;
  assign Locked   = (state_p1 == TRACK);
  assign Up       = up_p1;
  assign Err      = err_p1;
  assign Error    = error_p1;
  assign Overflow = ovf_p1;
  assign WrapCnt  = wrap_p1;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3, WRAP_W=8).
module tb_gray_decoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0;
  logic       Resync = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic [2:0] Bin;
  logic       Locked, Up, Down, Err, Error, Overflow;
  logic [7:0] WrapCnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] obs;
  logic [16:0] expv;
  logic [2:0]  gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_decoder #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Resync(Resync), .Gray(Gray),
    .Bin(Bin), .Locked(Locked), .Up(Up), .Down(Down), .Err(Err),
    .Error(Error), .Overflow(Overflow), .WrapCnt(WrapCnt)
  );

  always #5 Clk = ~Clk;

  assign obs = {Bin, Locked, Up, Down, Err, Error, Overflow, WrapCnt};

  function automatic logic [16:0] ev(input logic [2:0] b, input logic lk, up, dn, er, ers, ov,
                                     input logic [7:0] w);
    return {b, lk, up, dn, er, ers, ov, w};
  endfunction

  task automatic step(input logic en, input logic rs, input logic [2:0] g);
    @(negedge Clk);
    Reset = 1'b0; En = en; Resync = rs; Gray = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; En = 1'b0; Resync = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    expv = ev(3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL reset: got %h want %h", obs, expv); end
  endtask

  task automatic test_count();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, gseq[k]);
      expv = ev(3'(k), 1, (k != 0), 0, 0, 0, 0, 8'd0);
      n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL count_%0d: got %h want %h", k, obs, expv); end
    end
    step(1'b1, 1'b0, 3'b000);
    expv = ev(3'd0, 1, 1, 0, 0, 0, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL first_wrap: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b000);
    expv = ev(3'd0, 1, 0, 0, 0, 0, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL up_one_cycle: got %h want %h", obs, expv); end
  endtask

  task automatic test_wrap_sat();
    int want;
    for (int c = 1; c <= 255; c++) begin
      for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, gseq[k % 8]);
      want = (c + 1 > 255) ? 255 : c + 1;
      expv = ev(3'd0, 1, 1, 0, 0, 0, 1, 8'(want));
      n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL wrap_%0d: got %h want %h", c, obs, expv); end
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b0, 3'b011);
    expv = ev(3'd2, 1, 1, 0, 0, 0, 1, 8'd255);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL ill_setup: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b101);
    expv = ev(3'd2, 0, 0, 0, 1, 1, 1, 8'd255);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL ill_detect: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b010);
    expv = ev(3'd2, 0, 0, 0, 0, 1, 1, 8'd255);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL fault_ignore: got %h want %h", obs, expv); end
    step(1'b0, 1'b1, 3'b010);
    expv = ev(3'd2, 0, 0, 0, 0, 0, 1, 8'd255);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL resync_clear: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b111);
    expv = ev(3'd5, 1, 0, 0, 0, 0, 1, 8'd255);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL recapture: got %h want %h", obs, expv); end
  endtask

  task automatic test_down();
    do_reset();
    step(1'b1, 1'b0, 3'b000);
    expv = ev(3'd0, 1, 0, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL down_setup: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b100);
`ifdef GRAY_DOWN_EN
    expv = ev(3'd7, 1, 0, 1, 0, 0, 0, 8'd0);
`else
    expv = ev(3'd0, 0, 0, 0, 1, 1, 0, 8'd0);
`endif
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL down_step: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b100);
`ifdef GRAY_DOWN_EN
    expv = ev(3'd7, 1, 0, 0, 0, 0, 0, 8'd0);
`else
    expv = ev(3'd0, 0, 0, 0, 0, 1, 0, 8'd0);
`endif
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL down_after: got %h want %h", obs, expv); end
  endtask

  task automatic test_resync_en();
    do_reset();
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b001);
    expv = ev(3'd1, 1, 1, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rs_setup: got %h want %h", obs, expv); end
    step(1'b1, 1'b1, 3'b011);
    expv = ev(3'd1, 0, 0, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rs_discard: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b010);
    expv = ev(3'd3, 1, 0, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rs_capture: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b110);
    expv = ev(3'd4, 1, 1, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rs_track: got %h want %h", obs, expv); end
  endtask

  task automatic test_reset_fault();
    do_reset();
    step(1'b1, 1'b0, 3'b100);
    step(1'b1, 1'b0, 3'b000);
    expv = ev(3'd0, 1, 1, 0, 0, 0, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rf_wrap: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b011);
    expv = ev(3'd0, 0, 0, 0, 1, 1, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rf_fault: got %h want %h", obs, expv); end
    step(1'b0, 1'b1, 3'b000);
    expv = ev(3'd0, 0, 0, 0, 0, 0, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rf_resync_keep: got %h want %h", obs, expv); end
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b110);
    step(1'b0, 1'b0, 3'b000);
    expv = ev(3'd0, 0, 0, 0, 0, 1, 1, 8'd1);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rf_idle_hold: got %h want %h", obs, expv); end
    do_reset();
    expv = ev(3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    n_cmp++; if (obs !== expv) begin n_fail++; $display("FAIL rf_reset: got %h want %h", obs, expv); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap_sat();
    test_illegal();
    test_down();
    test_resync_en();
    test_reset_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Receiving end of the team's Gray-code counter link. It samples a WIDTH-bit Gray-coded bus and decodes each sample to binary. It checks that successive samples differ by exactly one code step and counts wrap-arounds of the remote counter. It sits downstream of a Gray counter, in the same clock domain, and reports position, step events, overflow and protocol errors to the control logic.

## Interface
- WIDTH, 3, Gray/binary code width; legal range 2..16.
- WRAP_W, 8, width of the wrap counter.

- Clk  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample strobe; Gray is taken on a rising Clk edge where En=1.
- Resync  input  1  drops lock; the next En sample re-captures without a step check.
- Gray  input  WIDTH  Gray-coded input value.
- Bin  output  WIDTH  decoded binary value of the last accepted sample.
- Locked  output  1  high while the block is in the TRACK state.
- Up  output  1  one-cycle pulse: the accepted sample was a +1 step.
- Down  output  1  one-cycle pulse: the accepted sample was a -1 step. Stays 0 unless GRAY_DOWN_EN is defined.
- Err  output  1  one-cycle pulse: illegal transition detected.
- Error  output  1  sticky illegal-transition flag.
- Overflow  output  1  sticky flag, set on an up-wrap from max to 0.
- WrapCnt  output  WRAP_W  net wrap count.

## Operation
- Decode rule: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Decoding is combinational on Gray; every result is registered.
- delta = decode(Gray) - Bin, computed modulo 2^WIDTH.
- State machine states: UNLOCKED, TRACK, FAULT.
- UNLOCKED & En: Bin<=decode(Gray); go to TRACK. No Up, Down or Err pulse; no wrap accounting.
- TRACK & En, by delta:
  - delta=0: hold. No pulse.
  - delta=1: Bin updates; Up=1. If the old Bin was all-ones and the new Bin is 0: Overflow<=1 and WrapCnt increments, saturating at all-ones.
  - delta=all-ones (a -1 step): handled per Configuration.
  - Any other delta: illegal. Bin holds; Err=1; Error<=1; go to FAULT.
- FAULT: every En sample is ignored and Bin holds. Only Resync or Reset leaves FAULT.
- Resync in any state: go to UNLOCKED; clear Error. Bin, WrapCnt and Overflow keep their values.
- With En=0 and Resync=0, state and outputs hold, and all pulses are 0.

## Timing
- Reset values: Bin=0, Locked=0, Up=0, Down=0, Err=0, Error=0, Overflow=0, WrapCnt=0. State is UNLOCKED.
- Latency: a sample taken at edge N is reflected in Bin, the pulses, the flags and WrapCnt right after edge N (one register stage).
- Up, Down and Err are high for exactly one cycle per event, even when En stays high on the next cycle.
- Locked rises on the edge of the first UNLOCKED sample. It falls on the edge that enters FAULT or applies Resync.
- Priority on one edge: Reset > Resync > En. If Resync and En are both 1, the sample is discarded and the state becomes UNLOCKED.
- Reset mid-operation clears everything, including the sticky flags and WrapCnt.
- Overflow is never cleared except by Reset.

## Configuration
- GRAY_DOWN_EN defined:
  - delta=all-ones in TRACK is a legal down-step: Bin updates and Down=1.
  - Old Bin 0 to new Bin all-ones decrements WrapCnt, saturating at 0. Overflow is unaffected.
- GRAY_DOWN_EN undefined:
  - delta=all-ones is illegal: Err/Error are set and the state goes to FAULT.
  - The Down output is tied to 0.

## Test plan
- Reset, then drive Gray 000,001,011,010,110,111,101,100 with En=1, WIDTH=3 -> Bin 0 first (capture, no Up), then Bin 1..7 with Up=1 on each of the 7 steps. Err=0 throughout.
- Continue from 100 to 000 -> Bin=0, Up=1, Overflow=1, WrapCnt=1. Repeat the full cycle 255 more times -> WrapCnt saturates at 255 and holds there.
- While locked at Bin=2 (Gray 011), drive Gray 101 -> Err pulses for 1 cycle, Error=1, Locked=0, Bin stays 2. Further samples are ignored until Resync; after Resync, Error=0 and the next sample re-captures.
- From Bin=0 (Gray 000), drive Gray 100 -> with GRAY_DOWN_EN: Bin=7, Down=1, WrapCnt saturates at 0. Without GRAY_DOWN_EN: Err=1 and FAULT.
- Assert Resync and En in the same cycle while in TRACK -> sample discarded, Locked=0, Bin unchanged. Assert Reset while in FAULT with Overflow=1 -> all outputs return to 0.
